// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped button/switch/seven-segment controller for the MIPS data port
module io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEN,
  input  logic [31:0] dataAdr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        io_sel,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [15:0] switch,
  output logic [7:0]  an,
  output logic [6:0]  a2g
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  logic [1:0] r_b_s0, r_b_s1, r_deb, r_deb_q, r_rdy;
  logic [DW-1:0] r_cnt [2];
  logic [15:0] r_sw_s0, r_sw_s1, r_swa, r_swb;
  logic [31:0] r_disp;
  logic [SW-1:0] r_pre;
  logic [2:0] r_idx;
  logic [1:0] w_press;
  logic [31:0] w_disp_nxt;
  logic [2:0] w_idx_nxt;
  logic w_wr, w_wrap, w_unused;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign io_sel = dataAdr[31:8] == 24'd0 && dataAdr[7:4] == 4'h8;
  assign w_wr = writeEN & io_sel;
  assign w_unused = &{1'b0, dataAdr[1:0]};
  assign w_press = r_deb & ~r_deb_q;
  assign readData = !io_sel ? 32'd0 :
                    dataAdr[3:2] == 2'd0 ? {30'd0, r_rdy} :
                    dataAdr[3:2] == 2'd1 ? {16'd0, r_swa} :
                    dataAdr[3:2] == 2'd2 ? r_disp : {16'd0, r_swb};
  assign w_wrap = r_pre == SW'(SCAN_CYCLES - 1);
  assign w_idx_nxt = w_wrap ? r_idx + 3'd1 : r_idx;
  // Segments follow the post-edge DISP and idx so a store shows on the lit digit immediately
  assign w_disp_nxt = (w_wr && dataAdr[3:2] == 2'd2) ? writeData : r_disp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_b_s0 <= '0;
      r_b_s1 <= '0;
      r_deb <= '0;
      r_deb_q <= '0;
      r_rdy <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      r_sw_s0 <= '0;
      r_sw_s1 <= '0;
      r_swa <= '0;
      r_swb <= '0;
      r_disp <= '0;
      r_pre <= '0;
      r_idx <= '0;
      an <= 8'hFE;
      a2g <= 7'b0000001;
    end else begin
      r_b_s0 <= {btnR, btnL};
      r_b_s1 <= r_b_s0;
      r_sw_s0 <= switch;
      r_sw_s1 <= r_sw_s0;
      for (int i = 0; i < 2; i++)
        if (r_b_s1[i] != r_deb[i]) begin
          if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else
            r_cnt[i] <= r_cnt[i] + DW'(1);
        end else
          r_cnt[i] <= '0;
      r_deb_q <= r_deb;
      // A press on the same edge as a software clear keeps the flag set
      r_rdy <= w_press | (r_rdy & ~({2{w_wr && dataAdr[3:2] == 2'd0}} & writeData[1:0]));
      if (w_press[0]) r_swa <= r_sw_s1;
      if (w_press[1]) r_swb <= r_sw_s1;
      r_disp <= w_disp_nxt;
      r_pre <= w_wrap ? '0 : r_pre + SW'(1);
      r_idx <= w_idx_nxt;
      an <= ~(8'd1 << w_idx_nxt);
      a2g <= hex7(w_disp_nxt[4*w_idx_nxt +: 4]);
    end
  end
endmodule
